// File: rtl/reg_scoreboard_if.sv
// Issue/writeback bundle between decode-issue, the scoreboard and the regfile write port.
// Carries the issue request, source operands, hazard/stall feedback, the retire strobe and the busy map.
// master = issue stage (drives request, sees stall/busy); slave = scoreboard.
interface reg_scoreboard_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = $clog2(WIDTH)
);
    logic                  issue_valid;
    logic                  issue_write;
    logic [ADDR_WIDTH-1:0] issue_wnum;
    logic [ADDR_WIDTH-1:0] rnum1;
    logic [ADDR_WIDTH-1:0] rnum2;
    logic                  busy_rnum1;
    logic                  busy_rnum2;
    logic                  stall;
    logic                  wb_valid;
    logic [ADDR_WIDTH-1:0] wb_wnum;
    logic [WIDTH-1:0]      busy_mask;

    modport master (
        output issue_valid, issue_write, issue_wnum, rnum1, rnum2,
        input  busy_rnum1, busy_rnum2, stall, wb_valid, wb_wnum, busy_mask
    );

    modport slave (
        input  issue_valid, issue_write, issue_wnum, rnum1, rnum2,
        output busy_rnum1, busy_rnum2, stall, wb_valid, wb_wnum, busy_mask
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Register write scoreboard: tracks every accepted register write until writeback retires it.
// Latency: a write accepted at edge N raises wb_valid DEPTH cycles later; busy/stall are combinational.
// Backpressure: stall (issue_valid and a busy source) refuses the issue; the tracking pipe never stops.
// Ports: clk, rst (async, active high); sb = slave side of reg_scoreboard_if (issue request, source
// operands, busy_rnum1/2, stall, wb_valid/wb_wnum retire strobe, busy_mask debug map).
module reg_scoreboard #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3     // legal range 1..8
) (
    input  logic            clk,
    input  logic            rst,
    reg_scoreboard_if.slave sb
);
    localparam int ADDR_WIDTH = $clog2(WIDTH);
    localparam int CNT_W      = $clog2(DEPTH + 1);

    // Tracking pipeline: stage 0 is loaded on accept, last stage feeds writeback.
    logic [DEPTH-1:0]      vld_q, vld_d;
    logic [ADDR_WIDTH-1:0] wnum_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wnum_d [DEPTH];

    // One pending-write counter per architectural register.
    logic [CNT_W-1:0]      cnt_q [WIDTH];
    logic [CNT_W-1:0]      cnt_d [WIDTH];

    logic [WIDTH-1:0]      busy_vec;
    logic [WIDTH-1:0]      inc_vec;
    logic [WIDTH-1:0]      dec_vec;
    logic                  busy1;
    logic                  busy2;
    logic                  stall_c;
    logic                  accept;
    logic                  load_vld;
    logic                  ret_vld;
    logic [ADDR_WIDTH-1:0] ret_wnum;

    assign ret_vld  = vld_q[DEPTH-1];
    assign ret_wnum = wnum_q[DEPTH-1];

    // Busy is read straight from the counters: a register retiring this cycle
    // still reads busy, there is no bypass from the retire stage.
    always_comb begin
        busy_vec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            busy_vec[i] = (cnt_q[i] != '0);
        end
        busy_vec[0] = 1'b0;
    end

    // Operand indices beyond WIDTH (non power-of-two register files) are never busy.
    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        if (32'(sb.rnum1) < WIDTH) busy1 = busy_vec[sb.rnum1];
        if (32'(sb.rnum2) < WIDTH) busy2 = busy_vec[sb.rnum2];
    end

    // WAW is deliberately not a hazard: only the source operands can stall.
    assign stall_c  = sb.issue_valid & (busy1 | busy2);
    assign accept   = sb.issue_valid & ~stall_c;
    assign load_vld = accept & sb.issue_write & (sb.issue_wnum != '0);

    always_comb begin
        vld_d     = '0;
        vld_d[0]  = load_vld;
        wnum_d[0] = load_vld ? sb.issue_wnum : '0;
        for (int k = 1; k < DEPTH; k++) begin
            vld_d[k]  = vld_q[k-1];
            wnum_d[k] = wnum_q[k-1];
        end
    end

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            inc_vec[i] = load_vld && (sb.issue_wnum == ADDR_WIDTH'(i));
            dec_vec[i] = ret_vld && (ret_wnum == ADDR_WIDTH'(i));
            // Simultaneous issue and retire of the same register cancel out.
            unique case ({inc_vec[i], dec_vec[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
                2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
        // r0 is hardwired zero and never tracked.
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                wnum_q[k] <= '0;
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            wnum_q <= wnum_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sb.busy_rnum1 = busy1;
    assign sb.busy_rnum2 = busy2;
    assign sb.stall      = stall_c;
    assign sb.wb_valid   = ret_vld;
    assign sb.wb_wnum    = ret_wnum;
    assign sb.busy_mask  = busy_vec;
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Writer-side hazard tracker: records every issued register write from issue until writeback retires it.
- Issue-stage read operands are flagged busy while any write to them is in flight; issue stalls on a hazard.
- Sits between decode/issue and the register file write port.
- Drives the writeback-side retire strobe for the register file and the busy map for debug.

Parameters:
- WIDTH, 32, number of architectural registers; ADDR_WIDTH = $clog2(WIDTH).
- DEPTH, 3, cycles from accepted issue to writeback retire; legal range 1 to 8.
- CNT_W, $clog2(DEPTH+1), derived (localparam): width of each per-register pending counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- issue_valid  input  1  an instruction is presented for issue this cycle.
- issue_write  input  1  the presented instruction writes a register.
- issue_wnum  input  ADDR_WIDTH  destination register number.
- rnum1  input  ADDR_WIDTH  source register 1 of the presented instruction.
- rnum2  input  ADDR_WIDTH  source register 2 of the presented instruction.
- busy_rnum1  output  1  rnum1 has a pending write.
- busy_rnum2  output  1  rnum2 has a pending write.
- stall  output  1  presented instruction is not accepted this cycle.
- wb_valid  output  1  a write retires this cycle.
- wb_wnum  output  ADDR_WIDTH  register retiring this cycle.
- busy_mask  output  WIDTH  bit i set when register i has at least one pending write.

Behaviour:
- Reset: asynchronous, active-high.
  - Clears all pipeline stages (valid=0, wnum=0) and all pending counters.
  - Outputs after reset: busy_rnum1=0, busy_rnum2=0, stall=0, wb_valid=0, wb_wnum=0, busy_mask=0.
  - Reset asserted mid-operation discards every in-flight write; no wb_valid pulse is produced for them.
- Tracking pipeline: DEPTH stages, each holding {valid, wnum}. It advances every cycle unconditionally.
- Accept rule:
  - accept = issue_valid & ~stall.
  - Stage 0 loads valid = accept & issue_write & (issue_wnum != 0), and wnum = issue_wnum.
  - Otherwise stage 0 loads a bubble.
- Retire: wb_valid and wb_wnum are driven registered from the last stage. A write accepted at edge N appears on wb_valid during the cycle after edge N+DEPTH-1, i.e. exactly DEPTH cycles of latency.
- Pending counters: one CNT_W-bit counter per register.
  - Increment on a valid stage-0 load to that register.
  - Decrement when the last stage retires that register (valid).
  - Increment and decrement on the same register in the same cycle: counter unchanged.
  - Counter can never exceed DEPTH. Overflow or underflow is a design error; the verification engineer checks it with an assertion.
- Register 0 is hardwired zero: it is never tracked, its counter stays 0, and busy_mask[0] is always 0.
- Busy outputs (combinational from state and current rnum inputs):
  - busy_rnumK = (cnt[rnumK] != 0).
  - busy_mask[i] = (cnt[i] != 0).
- No bypass: a register whose write retires in the current cycle still reads busy this cycle and reads not-busy the next cycle, provided no other write to it is pending.
- Stall: stall = issue_valid & (busy_rnum1 | busy_rnum2). WAW is not a hazard: issue_wnum busy does not stall, and the counter tracks multiple in-flight writes.
- Stall does not freeze the tracking pipeline; bubbles drain pending writes.
- Indices with rnum >= WIDTH (non-power-of-2 WIDTH) read as not busy.

Test Plan:
- Reset check:
  - Stimulus: assert rst asynchronously mid-cycle with 2 writes in flight.
  - Required: all outputs 0 immediately, and no wb_valid for 2*DEPTH cycles afterwards.
- Single write latency:
  - Stimulus: issue write to r5 at cycle 0.
  - Required: busy_mask[5]=1 in cycles 1..3; wb_valid=1, wb_wnum=5 in cycle 3; busy_mask[5]=0 from cycle 4 (DEPTH=3).
- RAW stall:
  - Stimulus: issue write r7, then an instruction reading rnum1=7.
  - Required: stall=1 with busy_rnum1=1 until r7 retires. The instruction is accepted the cycle after wb_valid with wb_wnum=7.
- Double pending write (WAW):
  - Stimulus: back-to-back writes to r3.
  - Required: counter reaches 2; busy stays 1 after the first retire; clears only after the second wb_valid.
- Register 0:
  - Stimulus: issue write to r0, then read rnum1=0 and rnum2=0.
  - Required: no wb_valid for r0; busy_rnum1=busy_rnum2=0; stall=0.
- Simultaneous set and clear:
  - Stimulus: issue a write to r9 in the same cycle an older r9 write retires.
  - Required: busy_mask[9] stays 1 continuously until the new write retires DEPTH cycles later.
